// File: rtl/dpram_arb_pkg.sv
// Shared types and default sizes for the dual-port RAM port arbiter.
// The requester index is one bit because the arbiter always serves exactly two masters.
package dpram_arb_pkg;

  localparam int DEF_DATA_WIDTH = 40;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_BE_WIDTH   = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/rr_pick2.sv
// Pure two-way round-robin pick: a lone requester always wins, and a tie goes to prio.
module rr_pick2
  import dpram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   prio,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one RAM port between two masters with round-robin arbitration, a bounded
// lock, and routing of the one-cycle-latency read data back to the issuing requester.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int Depth     = DEF_DEPTH,
  parameter int AddrWidth = $clog2(Depth),
  parameter int BeWidth   = DEF_BE_WIDTH,
  parameter int MaxBurst  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_i,
  input  logic [1:0]             lock_i,
  input  logic [1:0]             wren_i,
  input  logic [2*AddrWidth-1:0] addr_i,
  input  logic [2*DataWidth-1:0] wdata_i,
  input  logic [2*BeWidth-1:0]   be_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [AddrWidth-1:0]   ram_addr_o,
  output logic [DataWidth-1:0]   ram_din_o,
  output logic [BeWidth-1:0]     ram_be_o,
  output logic                   ram_wren_o,
  output logic                   ram_rden_o,
  input  logic [DataWidth-1:0]   ram_dout_i,
  output arb_state_e             state_o
);

  // Handshake: a requester raises req_i with stable addr/wdata/be/wren and holds
  // them until it sees gnt_o in the same cycle; the access completes on that edge.
  // A read's data arrives with rvalid_o one cycle after its grant.

  localparam int CntW = $clog2(MaxBurst + 1);

  arb_state_e      state_q, state_d;
  req_idx_t        prio_q, prio_d;
  req_idx_t        owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tag_valid_q;
  req_idx_t        tag_idx_q;

  logic [1:0] arb_win;
  logic [1:0] gnt;
  req_idx_t   win_idx;
  req_idx_t   sel;

  rr_pick2 u_pick (
    .req  (req_i),
    .prio (prio_q),
    .win  (arb_win)
  );

  assign win_idx = arb_win[1];

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt     = 2'b00;
    case (state_q)
      ARB: begin
        gnt = arb_win;
        if (|arb_win) begin
          prio_d = ~win_idx;
          // A one-beat burst limit would release on the same grant, so never lock.
          if (lock_i[win_idx] && (MaxBurst > 1)) begin
            state_d = LOCKED;
            owner_d = win_idx;
            cnt_d   = CntW'(1);
          end
        end
      end
      LOCKED: begin
        if (req_i[owner_q]) begin
          gnt[owner_q] = 1'b1;
          cnt_d        = cnt_q + 1'b1;
          if (!lock_i[owner_q] || (cnt_d == CntW'(MaxBurst))) begin
            state_d = ARB;
            prio_d  = ~owner_q;
            cnt_d   = '0;
          end
        end else begin
          state_d = ARB;
          prio_d  = ~owner_q;
          cnt_d   = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // With no grant, sel stays 0 so the port idles on requester-0 fields.
  assign sel        = gnt[1];
  assign gnt_o      = gnt;
  assign ram_addr_o = sel ? addr_i[2*AddrWidth-1:AddrWidth] : addr_i[AddrWidth-1:0];
  assign ram_din_o  = sel ? wdata_i[2*DataWidth-1:DataWidth] : wdata_i[DataWidth-1:0];
  assign ram_be_o   = sel ? be_i[2*BeWidth-1:BeWidth] : be_i[BeWidth-1:0];
  assign ram_wren_o = |(gnt & wren_i);
  assign ram_rden_o = |(gnt & ~wren_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_valid_q <= 1'b0;
      tag_idx_q   <= 1'b0;
    end else begin
      tag_valid_q <= ram_rden_o;
      tag_idx_q   <= sel;
    end
  end

  assign rvalid_o = tag_valid_q ? (tag_idx_q ? 2'b10 : 2'b01) : 2'b00;
  assign rdata_o  = ram_dout_i;
  assign state_o  = state_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a lane-gated one-cycle-latency RAM model.
module tb_dpram_port_arbiter;
  import dpram_arb_pkg::*;

  localparam int DW = 40;
  localparam int AW = 10;
  localparam int BW = 4;

  localparam logic [DW-1:0] WORD_5  = 40'h12_3456_789A;
  localparam logic [DW-1:0] WORD_A  = 40'h0A_AAAA_5555;
  localparam logic [DW-1:0] WORD_B  = 40'h0B_BBBB_CCCC;
  localparam logic [DW-1:0] ALL_ONE = 40'hFF_FFFF_FFFF;
  localparam logic [DW-1:0] PART_WR = 40'hFF_FFF0_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, lock, wren;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [2*BW-1:0] be;
  logic [1:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, ram_din, ram_dout;
  logic [AW-1:0]   ram_addr;
  logic [BW-1:0]   ram_be;
  logic            ram_wren, ram_rden;
  arb_state_e      state;

  logic            pre_en;
  logic [AW-1:0]   pre_addr;
  logic [DW-1:0]   pre_data;
  logic [DW-1:0]   mem [1024];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .lock_i     (lock),
    .wren_i     (wren),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .be_i       (be),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_be_o   (ram_be),
    .ram_wren_o (ram_wren),
    .ram_rden_o (ram_rden),
    .ram_dout_i (ram_dout),
    .state_o    (state)
  );

  // RAM model: each strobe lane covers 10 bits, read data registered.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_wren) begin
      for (int k = 0; k < BW; k++) begin
        if (ram_be[k]) mem[ram_addr][k*10 +: 10] <= ram_din[k*10 +: 10];
      end
    end
    if (ram_rden) ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_g;
    logic [1:0] lock_gnt [12];

    rst = 1'b1; req = '0; lock = '0; wren = '0;
    addr = '0; wdata = '0; be = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    tick();
    preload(10'h005, WORD_5);
    preload(10'h010, WORD_A);
    preload(10'h020, WORD_B);
    preload(10'h030, '0);

    // Reset state
    sample();
    check("rst_gnt", 64'(gnt), 64'(2'b00));
    check("rst_rvalid", 64'(rvalid), 64'(2'b00));
    check("rst_wren", 64'(ram_wren), 64'(1'b0));
    check("rst_rden", 64'(ram_rden), 64'(1'b0));
    check("rst_state", 64'(state), 64'(ARB));
    tick();
    rst = 1'b0;

    // Contention after reset: alternating reads from 0x010 (r0) and 0x020 (r1)
    addr = {10'h020, 10'h010};
    req  = 2'b11;
    for (int i = 0; i < 5; i++) begin
      sample();
      exp_g = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      check("cont_gnt", 64'(gnt), 64'(exp_g));
      if (i > 0) begin
        check("cont_rvalid", 64'(rvalid), 64'((i % 2 == 1) ? 2'b01 : 2'b10));
        check("cont_rdata", 64'(rdata), 64'((i % 2 == 1) ? WORD_A : WORD_B));
      end
      tick();
      if (i == 3) req = 2'b00;
    end

    // Single read of word 0x005 by requester 0
    addr = {10'h000, 10'h005};
    req  = 2'b01;
    sample();
    check("rd_gnt", 64'(gnt), 64'(2'b01));
    check("rd_rden", 64'(ram_rden), 64'(1'b1));
    check("rd_addr", 64'(ram_addr), 64'(10'h005));
    tick();
    req = 2'b00;
    sample();
    check("rd_rvalid", 64'(rvalid), 64'(2'b01));
    check("rd_rdata", 64'(rdata), 64'(WORD_5));
    tick();

    // Partial write with be=1100, then readback
    addr  = {10'h000, 10'h030};
    wdata = {40'h0, ALL_ONE};
    be    = {4'b0000, 4'b1100};
    wren  = 2'b01;
    req   = 2'b01;
    sample();
    check("wr_gnt", 64'(gnt), 64'(2'b01));
    check("wr_wren", 64'(ram_wren), 64'(1'b1));
    check("wr_rden", 64'(ram_rden), 64'(1'b0));
    check("wr_be", 64'(ram_be), 64'(4'b1100));
    check("wr_din", 64'(ram_din), 64'(ALL_ONE));
    tick();
    req = 2'b00; wren = 2'b00;
    sample();
    check("wr_no_rvalid", 64'(rvalid), 64'(2'b00));
    tick();
    req = 2'b01;
    sample();
    check("prd_gnt", 64'(gnt), 64'(2'b01));
    tick();
    req = 2'b00;
    sample();
    check("prd_rvalid", 64'(rvalid), 64'(2'b01));
    check("prd_rdata", 64'(rdata), 64'(PART_WR));
    tick();

    // Locked burst: prio points at r1 after the last r0 grant
    lock_gnt = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                 2'b01, 2'b10, 2'b10, 2'b10};
    addr = {10'h020, 10'h010};
    req  = 2'b11;
    lock = 2'b10;
    for (int i = 0; i < 12; i++) begin
      sample();
      check($sformatf("lock_gnt%0d", i), 64'(gnt), 64'(lock_gnt[i]));
      if (i == 1) begin
        check("lock_rvalid", 64'(rvalid), 64'(2'b10));
        check("lock_rdata", 64'(rdata), 64'(WORD_B));
      end
      if (i == 2) check("lock_state", 64'(state), 64'(LOCKED));
      if (i == 8) check("lock_released", 64'(state), 64'(ARB));
      tick();
    end

    // Idle release: owner r1 drops req for one cycle while r0 waits
    req = 2'b01;
    sample();
    check("idle_gnt", 64'(gnt), 64'(2'b00));
    check("idle_state", 64'(state), 64'(LOCKED));
    tick();
    req = 2'b11;
    sample();
    check("idle_next_gnt", 64'(gnt), 64'(2'b01));
    check("idle_next_state", 64'(state), 64'(ARB));
    tick();
    req = 2'b00; lock = 2'b00;
    tick();

    // Reset in the cycle after a read grant
    addr = {10'h000, 10'h005};
    req  = 2'b01;
    sample();
    check("rrst_gnt", 64'(gnt), 64'(2'b01));
    tick();
    rst = 1'b1;
    req = 2'b00;
    sample();
    check("rrst_rvalid", 64'(rvalid), 64'(2'b00));
    check("rrst_gnt0", 64'(gnt), 64'(2'b00));
    check("rrst_rden", 64'(ram_rden), 64'(1'b0));
    check("rrst_state", 64'(state), 64'(ARB));
    tick();
    rst  = 1'b0;
    addr = {10'h020, 10'h010};
    req  = 2'b11;
    sample();
    check("post_rst_gnt0", 64'(gnt), 64'(2'b01));
    check("post_rst_rvalid", 64'(rvalid), 64'(2'b00));
    tick();
    sample();
    check("post_rst_gnt1", 64'(gnt), 64'(2'b10));
    check("post_rst_rdata", 64'(rdata), 64'(WORD_A));
    tick();
    req = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Two-requester arbiter that shares one port of the 40-bit × 1024-word dual-port RAM between two independent masters, for example the core data path and the host/debug loader. It performs round-robin arbitration with an optional bounded bus lock, drives the RAM port signals, and routes the one-cycle-latency read data back to the requester that issued the read. It sits directly in front of one RAM port; the other RAM port is untouched.

## Interface
- DataWidth, 40, word width in bits
- Depth, 1024, number of words
- AddrWidth, $clog2(Depth), address width in bits
- BeWidth, 4, number of write-strobe lanes
- MaxBurst, 8, maximum consecutive locked grants to one requester (≥1)
- clk_i  in  1  single clock for all logic and for the RAM port
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  2  per-requester access request
- lock_i  in  2  per-requester lock request: keep ownership for the following beats
- wren_i  in  2  per-requester access type (1 = write, 0 = read)
- addr_i  in  2×AddrWidth  per-requester word address
- wdata_i  in  2×DataWidth  per-requester write data
- be_i  in  2×BeWidth  per-requester write strobes
- gnt_o  out  2  access accepted this cycle (one-hot or zero)
- rvalid_o  out  2  read data valid for that requester
- rdata_o  out  DataWidth  read data, shared by both requesters and qualified by rvalid_o
- ram_addr_o  out  AddrWidth  RAM port address
- ram_din_o  out  DataWidth  RAM port write data
- ram_be_o  out  BeWidth  RAM port write strobes
- ram_wren_o  out  1  RAM port write enable
- ram_rden_o  out  1  RAM port read enable
- ram_dout_i  in  DataWidth  RAM port read data (registered by the RAM, 1-cycle latency)

## Operation
- **FSM states.**
  - ARB: plain round-robin.
  - LOCKED: one owner holds the port.
- **ARB state.**
  - Grant rule:
    - If only one requester asserts req_i, that requester is granted.
    - If both assert req_i, the grant goes to the requester indicated by the priority pointer `prio` (reset value 0).
  - After any grant, `prio` is set to the non-granted index.
- **Entering LOCKED.**
  - Transition happens when the granted requester has lock_i=1.
  - owner := granted index; burst counter := 1.
- **LOCKED state.**
  - Only the owner can be granted. The other requester waits, with gnt_o=0.
  - Counter increments on each owner grant.
  - Return to ARB when any of these occurs:
    - the owner drops lock_i on a granted beat;
    - the owner is idle (req_i=0) for one cycle;
    - the counter reaches MaxBurst, which forces the release.
  - On exit, `prio` := the non-owner index, so the other requester wins the next contention.
- **Driving the RAM port.**
  - A grant copies the winner's addr/wdata/be onto the RAM port in the same cycle (combinational mux).
  - ram_wren_o = gnt & wren; ram_rden_o = gnt & ~wren.
  - When nothing is granted, ram_wren_o=0 and ram_rden_o=0; address and data outputs then hold the requester-0 fields.
- **Read return.**
  - A registered tag {valid, index} records each granted read.
  - On the next cycle, rvalid_o[index]=1 and rdata_o = ram_dout_i.
  - Writes produce no rvalid_o.
- **Write data.** The arbiter treats the 40-bit data as opaque. Lane gating is done by the RAM: lanes [3:2] control bits [39:20], lanes [1:0] control bits [19:0].

## Timing
- Grant is combinational in the same cycle as req_i; the RAM samples its inputs on the next clk_i edge.
- Read latency is 1 cycle: a grant at cycle N gives rvalid_o at N+1.
- Throughput is one access per cycle. Back-to-back grants to alternating requesters are legal, and their rvalid_o pulses appear in issue order.
- Requesters must hold req_i and all request fields stable until gnt_o.
- Reset values:
  - FSM=ARB, prio=0, counter=0, read tag invalid.
  - gnt_o=0, rvalid_o=0, rdata_o follows ram_dout_i (don't-care when not valid).
  - ram_wren_o=0, ram_rden_o=0.
- An asynchronous rst_i in mid-transfer does the following:
  - drops a read that is in flight (no rvalid_o);
  - releases the lock immediately;
  - leaves writes already sampled by the RAM intact.
- With MaxBurst=1, lock_i is effectively ignored and the FSM never stays in LOCKED past one grant.

## Structure
- A shared package `dpram_arb_pkg` holds:
  - the state enum `arb_state_e` {ARB, LOCKED};
  - the requester-index typedef;
  - the default width constants (40/1024/4).
- A single sub-module `rr_pick2` contains the pure round-robin selection: inputs req and prio, output a one-hot winner.
- The FSM, counter and read tag stay in the top module.

## Test plan
- **Single read.** Preload word 0x005 = 0x12_3456_789A; requester 0 reads 0x005.
  - gnt_o=01 in cycle N; rvalid_o=01 with rdata 0x123456789A in cycle N+1.
- **Contention after reset.** Both requesters request every cycle, no lock.
  - Grants alternate 01,10,01,10 starting with requester 0; each read is returned to the correct requester.
- **Locked burst.** Requester 1 holds lock_i=1 and req_i=1 for 12 beats while requester 0 also requests.
  - Requester 1 gets exactly 8 consecutive grants, then requester 0 is granted, then requester 1 resumes.
- **Partial write.** Requester 0 writes 0xFF_FFFF_FFFF with be=1100 to a word holding 0.
  - The readback is 0xFF_FFF0_0000.
- **Reset mid-read.** Assert rst_i in the cycle after a read grant.
  - No rvalid_o pulse; all outputs return to reset values; the next contention grants requester 0 first.
- **Idle release.** The lock owner drops req_i for one cycle while the other requester is waiting.
  - The FSM returns to ARB and the waiting requester is granted in the following cycle.
